// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers and engine types for the MixColumns datapath.
package aes_pkg;
   localparam int AES_BLOCK_W = 128;
   localparam int AES_COL_W   = 32;

   localparam logic [7:0] AES_GF_POLY = 8'h1B;
   localparam logic [7:0] GF_2 = 8'h02;
   localparam logic [7:0] GF_3 = 8'h03;
   localparam logic [7:0] GF_9 = 8'h09;
   localparam logic [7:0] GF_B = 8'h0B;
   localparam logic [7:0] GF_D = 8'h0D;
   localparam logic [7:0] GF_E = 8'h0E;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mc_state_e;

   typedef struct packed {
      logic [AES_BLOCK_W-1:0] data;
      logic                   inv;
      logic                   bypass;
   } mc_req_t;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_GF_POLY : 8'h00);
   endfunction

   // Multiplier c is always a constant at the call sites, so this folds to a few XORs.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] acc;
      logic [7:0] p;
      logic [7:0] cc;
      acc = 8'h00;
      p   = a;
      cc  = c;
      for (int i = 0; i < 8; i++) begin
         if (cc[0]) acc = acc ^ p;
         p  = xtime(p);
         cc = cc >> 1;
      end
      return acc;
   endfunction
endpackage

// File: rtl/mix_column_word.sv
// Combinational single-column MixColumns / InvMixColumns / pass-through transform.
module mix_column_word
   import aes_pkg::*;
(
   input  logic [AES_COL_W-1:0] col_in,
   input  logic                 inv,
   input  logic                 bypass,
   output logic [AES_COL_W-1:0] col_out
);
   // Element 3 is byte 0 (MSB byte) of the column.
   logic [3:0][7:0] a;
   logic [3:0][7:0] fwd;
   logic [3:0][7:0] rev;

   assign a = col_in;

   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int B0 = 3 - r;
      localparam int B1 = 3 - ((r + 1) % 4);
      localparam int B2 = 3 - ((r + 2) % 4);
      localparam int B3 = 3 - ((r + 3) % 4);
      assign fwd[3-r] = gf_mul(a[B0], GF_2) ^ gf_mul(a[B1], GF_3) ^ a[B2] ^ a[B3];
      assign rev[3-r] = gf_mul(a[B0], GF_E) ^ gf_mul(a[B1], GF_B)
                      ^ gf_mul(a[B2], GF_D) ^ gf_mul(a[B3], GF_9);
   end

   assign col_out = bypass ? col_in : (inv ? rev : fwd);
endmodule

// File: rtl/mix_columns_engine.sv
// Iterative MixColumns engine: transforms COLS_PER_CYCLE columns per BUSY cycle, valid/ready on both sides.
module mix_columns_engine
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] in_data,
   input  logic                   in_inv,
   input  logic                   in_bypass,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] out_data
);
   localparam int ITER    = 4 / COLS_PER_CYCLE;
   localparam int CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam int CHUNK_W = AES_COL_W * COLS_PER_CYCLE;

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   mc_state_e              state_q, state_d;
   logic [CNT_W-1:0]       col_cnt_q, col_cnt_d;
   mc_req_t                req_q, req_d;
   logic [AES_BLOCK_W-1:0] res_q, res_d;
   logic [AES_BLOCK_W-1:0] out_q, out_d;

   logic [CNT_W-1:0]                         chunk_idx;
   logic [6:0]                               lo;
   logic                                     last;
   logic [COLS_PER_CYCLE-1:0][AES_COL_W-1:0] lane_in;
   logic [COLS_PER_CYCLE-1:0][AES_COL_W-1:0] lane_out;

   // col_cnt 0 selects the most significant chunk, so the low bit offset counts down.
   assign chunk_idx = CNT_W'(ITER - 1) - col_cnt_q;
   assign lo        = 7'(int'(chunk_idx) * CHUNK_W);
   assign lane_in   = req_q.data[lo +: CHUNK_W];
   assign last      = (col_cnt_q == CNT_W'(ITER - 1));

   for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
      mix_column_word u_col (
         .col_in  (lane_in[l]),
         .inv     (req_q.inv),
         .bypass  (req_q.bypass),
         .col_out (lane_out[l])
      );
   end

   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      req_d     = req_q;
      res_d     = res_q;
      out_d     = out_q;
      in_ready  = 1'b0;
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_BUSY: begin
            res_d[lo +: CHUNK_W] = lane_out;
            col_cnt_d            = col_cnt_q + CNT_W'(1);
            if (last) begin
               col_cnt_d = '0;
               out_d     = res_d;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            in_ready = out_ready;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (rst) in_ready = 1'b0;
      // A DONE-state accept overrides the return to IDLE: next block starts with no bubble.
      if (in_valid && in_ready) begin
         req_d     = '{data: in_data, inv: in_inv, bypass: in_bypass};
         col_cnt_d = '0;
         state_d   = ST_BUSY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         col_cnt_q <= '0;
         req_q     <= '0;
         res_q     <= '0;
         out_q     <= '0;
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         req_q     <= req_d;
         res_q     <= res_d;
         out_q     <= out_d;
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign out_data  = out_q;
endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine at COLS_PER_CYCLE = 1, 2, 4 against a matrix-product GF(2^8) model.
module tb_mix_columns_engine;
   localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V_MIX   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V_BYP   = 128'h00112233_44556677_8899aabb_ccddeeff;

   logic         clk;
   logic         rst       [3];
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] in_data   [3];
   logic         in_inv    [3];
   logic         in_bypass [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] out_data  [3];

   int checks   = 0;
   int failures = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .in_inv    (in_inv[g]),
         .in_bypass (in_bypass[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Carry-less product then reduction modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++)
         if (((b >> i) & 8'h01) != 8'h00) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (((p >> i) & 16'h1) != 16'h0) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] ref_blk(input logic [127:0] d, input logic inv, input logic byp);
      logic [7:0]   coef [4];
      logic [7:0]   a    [4];
      logic [7:0]   acc;
      logic [31:0]  col;
      logic [127:0] o;
      if (byp) return d;
      if (inv) begin
         coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      end else begin
         coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      end
      o = '0;
      for (int c = 0; c < 4; c++) begin
         col = 32'(d >> (32 * (3 - c)));
         for (int k = 0; k < 4; k++) a[k] = 8'(col >> (8 * (3 - k)));
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], a[k]);
            o = {o[119:0], acc};
         end
      end
      return o;
   endfunction

   function automatic int iter_of(input int d);
      return 4 >> d;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input int d, output int n);
      n = 0;
      while (out_valid[d] !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
   endtask

   // Drive a block for exactly one edge, then scramble the inputs so later samples would show up.
   task automatic send(input int d, input logic [127:0] data, input logic inv, input logic byp);
      in_data[d]   = data;
      in_inv[d]    = inv;
      in_bypass[d] = byp;
      in_valid[d]  = 1'b1;
      tick();
      in_valid[d]  = 1'b0;
      in_data[d]   = ~data;
      in_inv[d]    = ~inv;
      in_bypass[d] = ~byp;
   endtask

   task automatic test_reset(input int d);
      tick();
      checks++; if (out_valid[d] !== 1'b0) begin failures++; $display("FAIL reset_out_valid cpc=%0d got=%b exp=0", 1 << d, out_valid[d]); end
      checks++; if (in_ready[d] !== 1'b0) begin failures++; $display("FAIL reset_in_ready_held cpc=%0d got=%b exp=0", 1 << d, in_ready[d]); end
      checks++; if (out_data[d] !== 128'h0) begin failures++; $display("FAIL reset_out_data cpc=%0d got=%h exp=0", 1 << d, out_data[d]); end
      rst[d] = 1'b0;
      #1;
      checks++; if (in_ready[d] !== 1'b1) begin failures++; $display("FAIL reset_in_ready_release cpc=%0d got=%b exp=1", 1 << d, in_ready[d]); end
   endtask

   task automatic test_vector(input int d, input string nm, input logic [127:0] data,
                              input logic inv, input logic byp, input logic [127:0] exp);
      int n;
      out_ready[d] = 1'b1;
      checks++; if (in_ready[d] !== 1'b1) begin failures++; $display("FAIL %s_ready cpc=%0d got=%b exp=1", nm, 1 << d, in_ready[d]); end
      send(d, data, inv, byp);
      wait_out(d, n);
      checks++; if (n != iter_of(d)) begin failures++; $display("FAIL %s_latency cpc=%0d got=%0d exp=%0d", nm, 1 << d, n, iter_of(d)); end
      checks++; if (out_data[d] !== exp) begin failures++; $display("FAIL %s_data cpc=%0d got=%h exp=%h", nm, 1 << d, out_data[d], exp); end
      tick();
      checks++; if (out_valid[d] !== 1'b0) begin failures++; $display("FAIL %s_drain cpc=%0d got=%b exp=0", nm, 1 << d, out_valid[d]); end
   endtask

   task automatic test_backpressure(input int d);
      logic [127:0] a, b;
      int n;
      a = rand128();
      b = rand128();
      out_ready[d] = 1'b0;
      send(d, a, 1'b0, 1'b0);
      wait_out(d, n);
      checks++; if (n != iter_of(d)) begin failures++; $display("FAIL bp_latency cpc=%0d got=%0d exp=%0d", 1 << d, n, iter_of(d)); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || out_data[d] !== ref_blk(a, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL bp_hold cpc=%0d cyc=%0d got=v%b r%b %h exp=v1 r0 %h", 1 << d, i,
                     out_valid[d], in_ready[d], out_data[d], ref_blk(a, 1'b0, 1'b0));
         end
         tick();
      end
      out_ready[d] = 1'b1;
      in_data[d]   = b;
      in_inv[d]    = 1'b1;
      in_bypass[d] = 1'b0;
      in_valid[d]  = 1'b1;
      #1;
      checks++; if (in_ready[d] !== 1'b1) begin failures++; $display("FAIL bp_same_cycle_ready cpc=%0d got=%b exp=1", 1 << d, in_ready[d]); end
      tick();
      in_valid[d] = 1'b0;
      checks++; if (out_valid[d] !== 1'b0) begin failures++; $display("FAIL bp_handoff_valid cpc=%0d got=%b exp=0", 1 << d, out_valid[d]); end
      wait_out(d, n);
      checks++; if (n != iter_of(d)) begin failures++; $display("FAIL bp2_latency cpc=%0d got=%0d exp=%0d", 1 << d, n, iter_of(d)); end
      checks++; if (out_data[d] !== ref_blk(b, 1'b1, 1'b0)) begin failures++; $display("FAIL bp2_data cpc=%0d got=%h exp=%h", 1 << d, out_data[d], ref_blk(b, 1'b1, 1'b0)); end
      tick();
   endtask

   task automatic test_reset_mid(input int d);
      int n;
      out_ready[d] = 1'b1;
      send(d, V_PLAIN, 1'b0, 1'b0);
      repeat ((iter_of(d) > 2) ? 2 : iter_of(d) - 1) tick();
      rst[d] = 1'b1;
      tick();
      rst[d] = 1'b0;
      #1;
      checks++; if (out_valid[d] !== 1'b0 || out_data[d] !== 128'h0) begin failures++; $display("FAIL midrst_out cpc=%0d got=v%b %h exp=v0 0", 1 << d, out_valid[d], out_data[d]); end
      checks++; if (in_ready[d] !== 1'b1) begin failures++; $display("FAIL midrst_ready cpc=%0d got=%b exp=1", 1 << d, in_ready[d]); end
      repeat (6) tick();
      checks++; if (out_valid[d] !== 1'b0) begin failures++; $display("FAIL midrst_dropped cpc=%0d got=%b exp=0", 1 << d, out_valid[d]); end
      test_vector(d, "midrst_fwd", V_PLAIN, 1'b0, 1'b0, V_MIX);
      // Reset while a result is held under backpressure also drops it.
      out_ready[d] = 1'b0;
      send(d, V_BYP, 1'b0, 1'b0);
      wait_out(d, n);
      rst[d] = 1'b1;
      tick();
      rst[d] = 1'b0;
      #1;
      checks++; if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin failures++; $display("FAIL donerst cpc=%0d got=v%b r%b exp=v0 r1", 1 << d, out_valid[d], in_ready[d]); end
      out_ready[d] = 1'b1;
   endtask

   task automatic test_roundtrip(input int d, input int nblk);
      logic [127:0] p, f;
      int n;
      out_ready[d] = 1'b1;
      for (int i = 0; i < nblk; i++) begin
         p = rand128();
         send(d, p, 1'b0, 1'b0);
         wait_out(d, n);
         f = out_data[d];
         checks++; if (out_valid[d] !== 1'b1 || f !== ref_blk(p, 1'b0, 1'b0)) begin failures++; $display("FAIL rt_fwd cpc=%0d blk=%0d got=%h exp=%h", 1 << d, i, f, ref_blk(p, 1'b0, 1'b0)); end
         tick();
         send(d, f, 1'b1, 1'b0);
         wait_out(d, n);
         checks++; if (out_valid[d] !== 1'b1 || out_data[d] !== p) begin failures++; $display("FAIL rt_inv cpc=%0d blk=%0d got=%h exp=%h", 1 << d, i, out_data[d], p); end
         tick();
      end
   endtask

   task automatic test_back_to_back(input int d, input int cycles, input logic full);
      logic [127:0] q[$];
      int got;
      got = 0;
      for (int c = 0; c < cycles + 64; c++) begin
         if (c < cycles) begin
            in_valid[d]  = full ? 1'b1 : ($urandom_range(3) != 0);
            out_ready[d] = full ? 1'b1 : ($urandom_range(3) != 0);
         end else begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
         end
         in_data[d]   = rand128();
         in_inv[d]    = 1'($urandom_range(1));
         in_bypass[d] = ($urandom_range(7) == 0);
         #1;
         if (out_valid[d] === 1'b1) begin
            checks++; if (in_ready[d] !== out_ready[d]) begin failures++; $display("FAIL stream_ready cpc=%0d cyc=%0d got=%b exp=%b", 1 << d, c, in_ready[d], out_ready[d]); end
            if (out_ready[d]) begin
               checks++;
               if (q.size() == 0 || out_data[d] !== q[0]) begin
                  failures++;
                  $display("FAIL stream_data cpc=%0d cyc=%0d got=%h exp=%h", 1 << d, c, out_data[d], (q.size() != 0) ? q[0] : 128'h0);
               end
               if (q.size() != 0) void'(q.pop_front());
               got++;
            end
         end
         if (in_valid[d] && in_ready[d] === 1'b1) q.push_back(ref_blk(in_data[d], in_inv[d], in_bypass[d]));
         tick();
      end
      checks++; if (q.size() != 0 || got == 0) begin failures++; $display("FAIL stream_drain cpc=%0d got=left%0d done%0d exp=left0 done>0", 1 << d, q.size(), got); end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = '0;
         in_inv[d] = 1'b0; in_bypass[d] = 1'b0; out_ready[d] = 1'b0;
      end
      for (int d = 0; d < 3; d++) begin
         test_reset(d);
         test_vector(d, "fwd", V_PLAIN, 1'b0, 1'b0, V_MIX);
         test_vector(d, "inv", V_MIX, 1'b1, 1'b0, V_PLAIN);
         test_vector(d, "bypass", V_BYP, 1'b1, 1'b1, V_BYP);
         test_backpressure(d);
         test_reset_mid(d);
         test_roundtrip(d, 1000);
         test_back_to_back(d, 200, 1'b1);
         test_back_to_back(d, 300, 1'b0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
